// File: rtl/qkv_result_writer_pkg.sv
// Shared constants and types for the Q/K/V result writer that sits behind the linear projection.
// Defaults describe one tile of 4 heads x 2 rows, 3 tiles per sequence, 16 BRAM words per head.
package qkv_result_writer_pkg;

  localparam int OUT_KEYS      = 16;
  localparam int NUM_HEADS     = 4;
  localparam int TOTAL_INPUT_W = 2;
  localparam int NUM_TILES     = 3;
  localparam int HEAD_STRIDE   = 16;

  typedef enum logic {
    WR_IDLE,
    WR_WRITE
  } wr_state_t;

  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/qkv_result_writer_if.sv
// Tile hand-off from the projection stage plus the shared Q/K/V BRAM write port.
// master = projection/BRAM side, slave = the writer.
interface qkv_result_writer_if #(
  parameter int OUT_W     = 16,
  parameter int NUM_HEADS = 4,
  parameter int ROWS      = 2,
  parameter int ADDR_W    = 6
);

  logic                                         in_valid;
  logic                                         in_ready;
  logic [NUM_HEADS-1:0][ROWS-1:0][OUT_W-1:0]    in_q;
  logic [NUM_HEADS-1:0][ROWS-1:0][OUT_W-1:0]    in_k;
  logic [NUM_HEADS-1:0][ROWS-1:0][OUT_W-1:0]    in_v;

  logic                                         out_we;
  logic [ADDR_W-1:0]                            out_addr;
  logic [OUT_W-1:0]                             out_q_din;
  logic [OUT_W-1:0]                             out_k_din;
  logic [OUT_W-1:0]                             out_v_din;

  modport master (
    output in_valid, in_q, in_k, in_v,
    input  in_ready,
    input  out_we, out_addr, out_q_din, out_k_din, out_v_din
  );

  modport slave (
    input  in_valid, in_q, in_k, in_v,
    output in_ready,
    output out_we, out_addr, out_q_din, out_k_din, out_v_din
  );

endinterface

// File: rtl/qkv_result_writer.sv
// Snapshots one tile of per-head Q/K/V rows and serialises it into three BRAM write ports,
// one row per cycle, counting tiles and flagging done after the final tile of a sequence.
module qkv_result_writer
  import qkv_result_writer_pkg::*;
#(
  parameter int OUT_W       = OUT_KEYS,
  parameter int NUM_HEADS   = qkv_result_writer_pkg::NUM_HEADS,
  parameter int ROWS        = TOTAL_INPUT_W,
  parameter int NUM_TILES   = qkv_result_writer_pkg::NUM_TILES,
  parameter int HEAD_STRIDE = qkv_result_writer_pkg::HEAD_STRIDE,
  parameter int ADDR_W      = $clog2(NUM_HEADS * HEAD_STRIDE),
  localparam int TILE_W     = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  qkv_result_writer_if.slave bus,
  output logic              busy,
  output logic [TILE_W-1:0] tile_idx,
  output logic              done,
  output logic              overflow
);

  localparam int ROW_W  = clog2_min1(ROWS);
  localparam int HEAD_W = clog2_min1(NUM_HEADS);

  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);
  localparam logic [HEAD_W-1:0] HEAD_LAST = HEAD_W'(NUM_HEADS - 1);
  localparam logic [TILE_W-1:0] TILE_LAST = TILE_W'(NUM_TILES - 1);

  typedef logic [NUM_HEADS-1:0][ROWS-1:0][OUT_W-1:0] tile_t;

  // Each head owns a HEAD_STRIDE window; every tile must fit inside it.
  generate
    if (HEAD_STRIDE < NUM_TILES * ROWS) begin : g_stride_check
      $error("qkv_result_writer: HEAD_STRIDE must be >= NUM_TILES*ROWS");
    end
  endgenerate

  function automatic logic [ADDR_W-1:0] wr_addr(
    input logic [HEAD_W-1:0] h,
    input logic [TILE_W-1:0] t,
    input logic [ROW_W-1:0]  r
  );
    return ADDR_W'(h) * ADDR_W'(HEAD_STRIDE) + ADDR_W'(t) * ADDR_W'(ROWS) + ADDR_W'(r);
  endfunction

  wr_state_t          state, state_nxt;
  logic [ROW_W-1:0]   row, row_nxt;
  logic [HEAD_W-1:0]  head, head_nxt;
  logic [TILE_W-1:0]  tile_nxt;
  logic               done_nxt;
  logic               ovf_nxt;
  logic               load;

  tile_t              snap_q, snap_k, snap_v;

  logic               we_r, we_nxt;
  logic [ADDR_W-1:0]  addr_r, addr_nxt;
  logic [OUT_W-1:0]   q_din_r, k_din_r, v_din_r;
  logic [OUT_W-1:0]   q_din_nxt, k_din_nxt, v_din_nxt;
  logic               in_ready;

  assign in_ready      = (state == WR_IDLE);
  assign busy          = (state != WR_IDLE);
  assign bus.in_ready  = in_ready;
  assign bus.out_we    = we_r;
  assign bus.out_addr  = addr_r;
  assign bus.out_q_din = q_din_r;
  assign bus.out_k_din = k_din_r;
  assign bus.out_v_din = v_din_r;

  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    head_nxt  = head;
    tile_nxt  = tile_idx;
    done_nxt  = done;
    ovf_nxt   = overflow;
    load      = 1'b0;
    we_nxt    = 1'b0;
    addr_nxt  = addr_r;
    q_din_nxt = q_din_r;
    k_din_nxt = k_din_r;
    v_din_nxt = v_din_r;

    // start outranks every other synchronous event, including a pending accept.
    if (start) begin
      state_nxt = WR_IDLE;
      tile_nxt  = '0;
      done_nxt  = 1'b0;
      ovf_nxt   = 1'b0;
    end else begin
      if (bus.in_valid && !in_ready) begin
        ovf_nxt = 1'b1;
      end
      case (state)
        WR_IDLE: begin
          if (bus.in_valid) begin
            load      = 1'b1;
            row_nxt   = '0;
            head_nxt  = '0;
            state_nxt = WR_WRITE;
          end
        end
        WR_WRITE: begin
          we_nxt    = 1'b1;
          addr_nxt  = wr_addr(head, tile_idx, row);
          q_din_nxt = snap_q[head][row];
          k_din_nxt = snap_k[head][row];
          v_din_nxt = snap_v[head][row];
          if (row == ROW_LAST) begin
            row_nxt = '0;
            if (head == HEAD_LAST) begin
              head_nxt  = '0;
              state_nxt = WR_IDLE;
              if (tile_idx == TILE_LAST) begin
                tile_nxt = '0;
                done_nxt = 1'b1;
              end else begin
                tile_nxt = tile_idx + 1'b1;
              end
            end else begin
              head_nxt = head + 1'b1;
            end
          end else begin
            row_nxt = row + 1'b1;
          end
        end
        default: state_nxt = WR_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= WR_IDLE;
      row      <= '0;
      head     <= '0;
      tile_idx <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
      we_r     <= 1'b0;
      addr_r   <= '0;
      q_din_r  <= '0;
      k_din_r  <= '0;
      v_din_r  <= '0;
      snap_q   <= '0;
      snap_k   <= '0;
      snap_v   <= '0;
    end else begin
      state    <= state_nxt;
      row      <= row_nxt;
      head     <= head_nxt;
      tile_idx <= tile_nxt;
      done     <= done_nxt;
      overflow <= ovf_nxt;
      we_r     <= we_nxt;
      addr_r   <= addr_nxt;
      q_din_r  <= q_din_nxt;
      k_din_r  <= k_din_nxt;
      v_din_r  <= v_din_nxt;
      if (load) begin
        snap_q <= bus.in_q;
        snap_k <= bus.in_k;
        snap_v <= bus.in_v;
      end
    end
  end

endmodule

// File: tb/tb_qkv_result_writer.sv
// Directed-plus-random bench for qkv_result_writer; expected writes come from a
// tile/address model built from the head/tile/row layout rules.
module tb_qkv_result_writer;

  localparam int W  = 16;
  localparam int NH = 4;
  localparam int R  = 2;
  localparam int NT = 3;
  localparam int HS = 16;
  localparam int AW = 6;

  typedef logic [NH-1:0][R-1:0][W-1:0] tile_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       busy;
  logic [1:0] tile_idx;
  logic       done;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  int  m_tile = 0;
  bit  m_done = 1'b0;
  bit  m_ovf  = 1'b0;

  qkv_result_writer_if #(.OUT_W(W), .NUM_HEADS(NH), .ROWS(R), .ADDR_W(AW)) bus ();

  qkv_result_writer #(
    .OUT_W      (W),
    .NUM_HEADS  (NH),
    .ROWS       (R),
    .NUM_TILES  (NT),
    .HEAD_STRIDE(HS),
    .ADDR_W     (AW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bus     (bus),
    .busy    (busy),
    .tile_idx(tile_idx),
    .done    (done),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic tile_t rand_tile();
    tile_t t;
    for (int h = 0; h < NH; h++)
      for (int r = 0; r < R; r++)
        t[h][r] = W'($urandom);
    return t;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one tile and follows it through its writes. hold keeps in_valid high during WRITE,
  // abort_at issues start in place of that write index, idle_chk looks one cycle past the tile.
  task automatic do_tile(input tile_t q, input tile_t k, input tile_t v,
                         input bit hold, input int abort_at, input bit idle_chk);
    int h;
    int r;
    chk("ready_before_accept", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_q = q;
    bus.in_k = k;
    bus.in_v = v;
    step();
    chk("busy_after_accept", busy, 1);
    chk("ready_after_accept", bus.in_ready, 0);
    chk("we_after_accept", bus.out_we, 0);
    if (!hold) bus.in_valid = 1'b0;
    bus.in_q = rand_tile();
    bus.in_k = rand_tile();
    bus.in_v = rand_tile();
    for (int i = 0; i < NH * R; i++) begin
      h = i / R;
      r = i % R;
      if (i == abort_at) begin
        start = 1'b1;
        step();
        start = 1'b0;
        bus.in_valid = 1'b0;
        m_tile = 0;
        m_done = 1'b0;
        m_ovf  = 1'b0;
        chk("abort_we", bus.out_we, 0);
        chk("abort_tile", tile_idx, m_tile);
        chk("abort_done", done, m_done);
        chk("abort_ovf", overflow, m_ovf);
        chk("abort_ready", bus.in_ready, 1);
        return;
      end
      step();
      if (hold) m_ovf = 1'b1;
      chk("write_we", bus.out_we, 1);
      chk("write_addr", bus.out_addr, h * HS + m_tile * R + r);
      chk("write_q", bus.out_q_din, q[h][r]);
      chk("write_k", bus.out_k_din, k[h][r]);
      chk("write_v", bus.out_v_din, v[h][r]);
    end
    bus.in_valid = 1'b0;
    if (m_tile == NT - 1) m_done = 1'b1;
    m_tile = (m_tile + 1) % NT;
    chk("tile_after", tile_idx, m_tile);
    chk("done_after", done, m_done);
    chk("ovf_after", overflow, m_ovf);
    chk("ready_after", bus.in_ready, 1);
    if (idle_chk) begin
      step();
      chk("idle_we", bus.out_we, 0);
      chk("idle_busy", busy, 0);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_we"}, bus.out_we, 0);
    chk({tag, "_addr"}, bus.out_addr, 0);
    chk({tag, "_q"}, bus.out_q_din, 0);
    chk({tag, "_k"}, bus.out_k_din, 0);
    chk({tag, "_v"}, bus.out_v_din, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ready"}, bus.in_ready, 1);
    chk({tag, "_tile"}, tile_idx, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ovf"}, overflow, 0);
  endtask

  initial begin
    tile_t dq, dk, dv;
    bus.in_valid = 1'b0;
    bus.in_q = '0;
    bus.in_k = '0;
    bus.in_v = '0;

    // Power-on reset
    step();
    step();
    chk_reset_values("reset");
    rst = 1'b0;

    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_tile", tile_idx, 0);
    chk("start_done", done, 0);

    // Directed first tile: q[h][r] = 0x0100*h + r
    for (int h = 0; h < NH; h++)
      for (int r = 0; r < R; r++) begin
        dq[h][r] = W'(16'h0100 * h + r);
        dk[h][r] = W'(16'h0100 * h + r) ^ 16'h5A5A;
        dv[h][r] = W'($urandom);
      end
    do_tile(dq, dk, dv, 1'b0, -1, 1'b0);

    // Back-to-back second tile, then third tile with in_valid held through WRITE
    do_tile(rand_tile(), rand_tile(), rand_tile(), 1'b0, -1, 1'b1);
    do_tile(rand_tile(), rand_tile(), rand_tile(), 1'b1, -1, 1'b1);

    // Tile after done wraps to tile 0 and done stays set
    do_tile(rand_tile(), rand_tile(), rand_tile(), 1'b0, -1, 1'b1);

    // start after three writes, then a fresh tile from address 0
    do_tile(rand_tile(), rand_tile(), rand_tile(), 1'b0, 3, 1'b0);
    do_tile(rand_tile(), rand_tile(), rand_tile(), 1'b0, -1, 1'b1);

    // start and in_valid together: tile is not taken
    start = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_q = rand_tile();
    step();
    start = 1'b0;
    bus.in_valid = 1'b0;
    m_tile = 0;
    chk("startvalid_busy", busy, 0);
    chk("startvalid_ready", bus.in_ready, 1);
    chk("startvalid_tile", tile_idx, m_tile);
    step();
    chk("startvalid_we", bus.out_we, 0);

    // Advance one tile, then asynchronous reset in the middle of the next one
    do_tile(rand_tile(), rand_tile(), rand_tile(), 1'b0, -1, 1'b1);
    chk("pre_rst_tile", tile_idx, 1);
    bus.in_valid = 1'b1;
    bus.in_q = rand_tile();
    bus.in_k = rand_tile();
    bus.in_v = rand_tile();
    step();
    bus.in_valid = 1'b0;
    step();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk_reset_values("async_rst");
    step();
    rst = 1'b0;
    m_tile = 0;
    m_done = 1'b0;
    m_ovf  = 1'b0;

    do_tile(rand_tile(), rand_tile(), rand_tile(), 1'b0, -1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
